// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshake
module cla_adder_pipe #(
  parameter int WIDTH = 8,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [WIDTH:0]   out
);
  localparam int NG = WIDTH / GROUP;
  logic [WIDTH-1:0] b_eff, p, g, p_r, g_r, nxt_sum;
  logic [NG-1:0] gp, gg, gp_r, gg_r;
  logic [NG:0] gc;
  logic c0_r, a_msb_r, b_msb_r, s1_valid, adv, bc, nxt_ovf;
  assign b_eff = sub ? ~b : b;
  assign p = a ^ b_eff;
  assign g = a & b_eff;
  always_comb begin
    gg = '0;
    for (int k = 0; k < NG; k++) begin
      gp[k] = &p[k*GROUP +: GROUP];
      for (int j = 0; j < GROUP; j++) gg[k] = g[k*GROUP+j] | (p[k*GROUP+j] & gg[k]);
    end
  end
  // group carries first, then each group's bit carries seeded from its group carry
  always_comb begin
    gc[0] = c0_r;
    for (int k = 0; k < NG; k++) gc[k+1] = gg_r[k] | (gp_r[k] & gc[k]);
    nxt_sum = '0;
    bc = 1'b0;
    for (int k = 0; k < NG; k++) begin
      bc = gc[k];
      for (int j = 0; j < GROUP; j++) begin
        nxt_sum[k*GROUP+j] = p_r[k*GROUP+j] ^ bc;
        bc = g_r[k*GROUP+j] | (p_r[k*GROUP+j] & bc);
      end
    end
    nxt_ovf = (a_msb_r == b_msb_r) && (nxt_sum[WIDTH-1] != a_msb_r);
  end
  assign adv = !out_valid || out_ready;
  assign in_ready = adv || !s1_valid;
  assign out = {cout, sum};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      p_r <= '0;
      g_r <= '0;
      gp_r <= '0;
      gg_r <= '0;
      c0_r <= 1'b0;
      a_msb_r <= 1'b0;
      b_msb_r <= 1'b0;
      out_valid <= 1'b0;
      sum <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        p_r <= p;
        g_r <= g;
        gp_r <= gp;
        gg_r <= gg;
        c0_r <= sub | cin;
        a_msb_r <= a[WIDTH-1];
        b_msb_r <= b_eff[WIDTH-1];
      end
      if (adv) begin
        out_valid <= s1_valid;
        sum <= nxt_sum;
        cout <= gc[NG];
        ovf <= nxt_ovf;
      end
    end
  end
endmodule
